// File: rtl/n64_pkg.sv
// Shared joybus definitions for the device-side responder and the host-side poller.
package n64_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  // Bit-cell phase lengths in microseconds: a '1' is short-low/long-high,
  // a '0' is long-low/short-high, and the stop bit is a 2 us low.
  localparam int PHASE_SHORT_US = 1;
  localparam int PHASE_STOP_US  = 2;
  localparam int PHASE_LONG_US  = 3;

  typedef enum logic [3:0] {
    IDLE,
    RX_LOW,
    RX_HIGH,
    RX_STOP,
    TURNAROUND,
    TX_LOW,
    TX_HIGH,
    TX_STOP,
    WAIT_RELEASE
  } n64_rsp_state_t;

  function automatic logic is_supported(input logic [7:0] code);
    return (code == CMD_STATUS) || (code == CMD_POLL) || (code == CMD_RESET);
  endfunction

endpackage

// File: rtl/n64_controller_responder_if.sv
// Joybus line plus the command/response status signals of the responder.
interface n64_controller_responder_if;
  logic        line_in;
  logic        line_drive_low;
  logic [31:0] buttons;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        cmd_error;
  logic        rsp_done;
  logic        busy;

  modport slave (
    input  line_in, buttons,
    output line_drive_low, cmd_valid, cmd_code, cmd_error, rsp_done, busy
  );

  modport master (
    output line_in, buttons,
    input  line_drive_low, cmd_valid, cmd_code, cmd_error, rsp_done, busy
  );
endinterface

// File: rtl/n64_bit_encoder.sv
// Emits one joybus bit cell (or the 2 us stop pulse) per start pulse.
// done is asserted in the last cycle of the cell so a back-to-back start
// keeps the bit period exact.
module n64_bit_encoder
  import n64_pkg::*;
#(
  parameter int US_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  input  logic stop,
  output logic drive_low,
  output logic done
);

  localparam logic [15:0] SHORT_LEN = 16'(PHASE_SHORT_US * US_CYCLES);
  localparam logic [15:0] LONG_LEN  = 16'(PHASE_LONG_US * US_CYCLES);
  localparam logic [15:0] STOP_LEN  = 16'(PHASE_STOP_US * US_CYCLES);
  localparam logic [15:0] CELL_LEN  = SHORT_LEN + LONG_LEN;

  logic        active;
  logic [15:0] cnt;
  logic [15:0] low_len;
  logic [15:0] total_len;

  assign done = active && (cnt == total_len - 16'd1);

  // Cell timer: a start always wins so consecutive cells join seamlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      cnt       <= '0;
      low_len   <= '0;
      total_len <= '0;
      drive_low <= 1'b0;
    end else if (start) begin
      active    <= 1'b1;
      cnt       <= '0;
      drive_low <= 1'b1;
      low_len   <= stop ? STOP_LEN : (bit_val ? SHORT_LEN : LONG_LEN);
      total_len <= stop ? STOP_LEN : CELL_LEN;
    end else if (active) begin
      cnt <= cnt + 16'd1;
      if (cnt == low_len - 16'd1) drive_low <= 1'b0;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/n64_controller_responder.sv
// Device end of the N64 joybus: decodes a host command byte and answers with
// the status word or the captured button word. The line is only ever pulled
// low; the tri-state is built outside from line_drive_low.
module n64_controller_responder
  import n64_pkg::*;
#(
  parameter int          US_CYCLES     = 50,
  parameter int          TURNAROUND_US = 2,
  parameter int          TIMEOUT_US    = 8,
  parameter logic [23:0] STATUS_WORD   = 24'h050000
) (
  input logic                         clk,
  input logic                         rst,
  n64_controller_responder_if.slave   bus
);

  // A low of width cnt+1 decodes as '1' when shorter than 2 us.
  localparam logic [15:0] ONE_LIMIT    = 16'(2 * US_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US * US_CYCLES - 1);
  localparam logic [15:0] TURN_LAST    = 16'(TURNAROUND_US * US_CYCLES - 1);

  logic sync1, sync2, sync_q;
  logic fall, rise;

  n64_rsp_state_t state, state_nxt;
  logic [15:0]    phase_cnt;

  logic [3:0]  rx_idx;
  logic [7:0]  rx_sr;
  logic [7:0]  cmd_code_q;
  logic [31:0] tx_sr;
  logic [5:0]  tx_left;
  logic        cmd_valid_q, cmd_error_q, rsp_done_q;

  logic enc_start, enc_bit, enc_stop, enc_drive_low, enc_done;
  logic rx_start, rx_shift, rx_bit, cmd_take;
  logic load_status, load_poll, tx_advance;
  logic valid_nxt, error_nxt, done_nxt;

  // Two-flop synchronizer plus one delay flop for edge detection; idle bus is high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync1  <= bus.line_in;
      sync2  <= sync1;
      sync_q <= sync2;
    end
  end

  assign fall = sync_q & ~sync2;
  assign rise = ~sync_q & sync2;

  // State register and the shared saturating phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)       phase_cnt <= '0;
      else if (phase_cnt != 16'hFFFF) phase_cnt <= phase_cnt + 16'd1;
    end
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt   = state;
    enc_start   = 1'b0;
    enc_bit     = tx_sr[31];
    enc_stop    = 1'b0;
    rx_start    = 1'b0;
    rx_shift    = 1'b0;
    rx_bit      = (phase_cnt < ONE_LIMIT);
    cmd_take    = 1'b0;
    load_status = 1'b0;
    load_poll   = 1'b0;
    tx_advance  = 1'b0;
    valid_nxt   = 1'b0;
    error_nxt   = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: if (fall) begin
        rx_start  = 1'b1;
        state_nxt = RX_LOW;
      end
      RX_LOW: begin
        if (rise) begin
          rx_shift  = 1'b1;
          state_nxt = RX_HIGH;
        end else if (phase_cnt == TIMEOUT_LAST) begin
          error_nxt = 1'b1;
          state_nxt = WAIT_RELEASE;
        end
      end
      RX_HIGH: begin
        if (fall) begin
          state_nxt = (rx_idx == 4'd8) ? RX_STOP : RX_LOW;
        end else if (phase_cnt == TIMEOUT_LAST) begin
          error_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      RX_STOP: begin
        if (rise) begin
          cmd_take = 1'b1;
          if (is_supported(rx_sr)) begin
            valid_nxt   = 1'b1;
            load_poll   = (rx_sr == CMD_POLL);
            load_status = (rx_sr != CMD_POLL);
            state_nxt   = TURNAROUND;
          end else begin
            error_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end else if (phase_cnt == TIMEOUT_LAST) begin
          error_nxt = 1'b1;
          state_nxt = WAIT_RELEASE;
        end
      end
      TURNAROUND: if (phase_cnt == TURN_LAST) begin
        enc_start  = 1'b1;
        tx_advance = 1'b1;
        state_nxt  = TX_LOW;
      end
      TX_LOW, TX_HIGH: begin
        if (enc_done) begin
          enc_start = 1'b1;
          if (tx_left != 6'd0) begin
            tx_advance = 1'b1;
            state_nxt  = TX_LOW;
          end else begin
            enc_stop  = 1'b1;
            state_nxt = TX_STOP;
          end
        end else if (state == TX_LOW && !enc_drive_low) begin
          state_nxt = TX_HIGH;
        end
      end
      TX_STOP: if (enc_done) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      WAIT_RELEASE: if (sync2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Receive shifter, latched command, response payload and status strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_idx      <= '0;
      rx_sr       <= '0;
      cmd_code_q  <= '0;
      tx_sr       <= '0;
      tx_left     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
      rsp_done_q  <= 1'b0;
    end else begin
      cmd_valid_q <= valid_nxt;
      cmd_error_q <= error_nxt;
      rsp_done_q  <= done_nxt;
      if (rx_start) begin
        rx_idx <= '0;
      end else if (rx_shift) begin
        rx_idx <= rx_idx + 4'd1;
        rx_sr  <= {rx_sr[6:0], rx_bit};
      end
      if (cmd_take) cmd_code_q <= rx_sr;
      if (load_status) begin
        tx_sr   <= {STATUS_WORD, 8'h00};
        tx_left <= 6'd24;
      end else if (load_poll) begin
        tx_sr   <= bus.buttons;
        tx_left <= 6'd32;
      end else if (tx_advance) begin
        tx_sr   <= {tx_sr[30:0], 1'b0};
        tx_left <= tx_left - 6'd1;
      end
    end
  end

  n64_bit_encoder #(.US_CYCLES(US_CYCLES)) u_encoder (
    .clk       (clk),
    .rst       (rst),
    .start     (enc_start),
    .bit_val   (enc_bit),
    .stop      (enc_stop),
    .drive_low (enc_drive_low),
    .done      (enc_done)
  );

  assign bus.line_drive_low = enc_drive_low;
  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_code       = cmd_code_q;
  assign bus.cmd_error      = cmd_error_q;
  assign bus.rsp_done       = rsp_done_q;
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_n64_controller_responder.sv
// Bench for the joybus responder: a host model drives command bytes on an
// open-drain line, a monitor records every device low pulse, and expected
// responses are built from the command rules (status word or button word).
module tb_n64_controller_responder;

  localparam int          US         = 4;
  localparam int          TURN_US    = 2;
  localparam int          TO_US      = 8;
  localparam logic [23:0] STATUS     = 24'h050000;
  localparam int          SYNC_DELAY = 2;
  localparam int          LATENCY    = SYNC_DELAY + TURN_US * US + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_low = 1'b0;
  logic [31:0] buttons_drv = 32'h0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          last_release = 0;

  n64_controller_responder_if bus();

  assign bus.line_in = ~(host_low | bus.line_drive_low);
  assign bus.buttons = buttons_drv;

  n64_controller_responder #(
    .US_CYCLES     (US),
    .TURNAROUND_US (TURN_US),
    .TIMEOUT_US    (TO_US),
    .STATUS_WORD   (STATUS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobe counters and device pulse log, sampled mid-cycle.
  int   valid_cnt = 0, err_cnt = 0, done_cnt = 0, err_cyc = 0, run_len = 0;
  int   rise_q[$];
  int   low_q[$];
  logic ld_q = 1'b0;
  always @(negedge clk) begin
    if (bus.cmd_valid) valid_cnt++;
    if (bus.cmd_error) begin err_cnt++; err_cyc = cyc; end
    if (bus.rsp_done) done_cnt++;
    if (bus.line_drive_low) begin
      if (!ld_q) begin rise_q.push_back(cyc); run_len = 1; end
      else run_len++;
    end else if (ld_q) begin
      low_q.push_back(run_len);
    end
    ld_q = bus.line_drive_low;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic hold(input logic low, input int n);
    host_low = low;
    if (!low) last_release = cyc;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Host byte: '1' = 1 us low / 3 us high, '0' = 3 us low / 1 us high, stop = 1 us low.
  task automatic send_bits(input logic [7:0] code, input int nbits, input bit with_stop);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b1, code[7-i] ? US : 3 * US);
      hold(1'b0, code[7-i] ? 3 * US : US);
    end
    if (with_stop) begin
      hold(1'b1, US);
      host_low = 1'b0;
      last_release = cyc;
    end
  endtask

  task automatic run_cmd(input string name, input logic [7:0] code, input bit toggle_mid);
    int          v0, e0, d0, r0, l0, len, waited, bad_w, bad_p, n, rel;
    logic        supported;
    logic [31:0] exp_word, got;
    v0 = valid_cnt; e0 = err_cnt; d0 = done_cnt;
    r0 = rise_q.size(); l0 = low_q.size();
    supported = (code == 8'h00) || (code == 8'h01) || (code == 8'hFF);
    len       = (code == 8'h01) ? 32 : (supported ? 24 : 0);
    exp_word  = (code == 8'h01) ? buttons_drv : {8'h00, STATUS};
    send_bits(code, 8, 1'b1);
    rel = last_release;
    waited = 0;
    if (len != 0) begin
      while (done_cnt == d0 && waited < 1500) begin
        @(posedge clk); #1;
        waited++;
        if (toggle_mid && waited == 60) buttons_drv = ~exp_word;
      end
    end else begin
      repeat (200) begin @(posedge clk); #1; end
    end
    repeat (4) begin @(posedge clk); #1; end
    check({name, "_valid"}, 32'(valid_cnt - v0), supported ? 1 : 0);
    check({name, "_error"}, 32'(err_cnt - e0), supported ? 0 : 1);
    check({name, "_code"}, {24'h0, bus.cmd_code}, {24'h0, code});
    check({name, "_rsp_done"}, 32'(done_cnt - d0), (len != 0) ? 1 : 0);
    check({name, "_busy"}, {31'h0, bus.busy}, 32'h0);
    n = low_q.size() - l0;
    check({name, "_pulses"}, 32'(n), (len != 0) ? len + 1 : 0);
    if (len != 0 && n == len + 1) begin
      got = '0; bad_w = 0; bad_p = 0;
      for (int i = 0; i < len; i++) begin
        got = {got[30:0], (low_q[l0+i] < 2 * US)};
        if (low_q[l0+i] != (exp_word[len-1-i] ? US : 3 * US)) bad_w++;
        if (i > 0 && rise_q[r0+i] - rise_q[r0+i-1] != 4 * US) bad_p++;
      end
      check({name, "_word"}, got, exp_word);
      check({name, "_bit_width_errs"}, 32'(bad_w), 32'h0);
      check({name, "_bit_period_errs"}, 32'(bad_p), 32'h0);
      check({name, "_stop_width"}, 32'(low_q[l0+len]), 32'(2 * US));
      check({name, "_stop_start"}, 32'(rise_q[r0+len] - rise_q[r0+len-1]), 32'(4 * US));
      check({name, "_latency"}, 32'(rise_q[r0] - rel), 32'(LATENCY));
    end
    hold(1'b0, 10);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, d0, r0, l0, rel5, waited;
    logic [7:0] code;

    // Reset values.
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_drive", {31'h0, bus.line_drive_low}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_code", {24'h0, bus.cmd_code}, 32'h0);
    check("rst_strobes", {29'h0, bus.cmd_valid, bus.cmd_error, bus.rsp_done}, 32'h0);
    rst = 1'b0;
    hold(1'b0, 10);

    // Poll with a fixed button word, then status and reset commands.
    buttons_drv = 32'hA5C3_0F81;
    run_cmd("poll", 8'h01, 1'b0);
    run_cmd("status", 8'h00, 1'b0);
    run_cmd("reset_cmd", 8'hFF, 1'b0);

    // Unsupported command, then a normal poll.
    run_cmd("unsup", 8'h02, 1'b0);
    buttons_drv = $urandom;
    run_cmd("poll_after_unsup", 8'h01, 1'b0);

    // Five bits then a long high gap: aborted by the high-phase timeout.
    e0 = err_cnt; r0 = rise_q.size();
    send_bits(8'h01, 5, 1'b0);
    rel5 = last_release;
    repeat (40) begin @(posedge clk); #1; end
    check("partial_error", 32'(err_cnt - e0), 32'h1);
    check("partial_err_time_ok",
          32'((err_cyc - rel5 >= TO_US * US) && (err_cyc - rel5 <= TO_US * US + SYNC_DELAY + 2)), 32'h1);
    check("partial_busy", {31'h0, bus.busy}, 32'h0);
    check("partial_no_rsp", 32'(rise_q.size() - r0), 32'h0);
    buttons_drv = $urandom;
    run_cmd("poll_after_partial", 8'h01, 1'b0);

    // Line stuck low: error, then hold in wait-release until high.
    e0 = err_cnt; r0 = rise_q.size();
    hold(1'b1, 50);
    check("stuck_error", 32'(err_cnt - e0), 32'h1);
    check("stuck_busy_low", {31'h0, bus.busy}, 32'h1);
    hold(1'b0, 6);
    check("stuck_busy_released", {31'h0, bus.busy}, 32'h0);
    check("stuck_no_rsp", 32'(rise_q.size() - r0), 32'h0);
    hold(1'b0, 10);

    // Buttons changed mid-response must not alter the word in flight.
    buttons_drv = $urandom;
    run_cmd("poll_toggle", 8'h01, 1'b1);

    // Randomized command mix against the rule-based model.
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0:       code = 8'h00;
        1:       code = 8'h01;
        2:       code = 8'hFF;
        default: code = 8'($urandom);
      endcase
      buttons_drv = $urandom;
      run_cmd("rand", code, 1'b0);
    end

    // Reset during the 10th response bit.
    d0 = done_cnt; r0 = rise_q.size(); l0 = low_q.size();
    buttons_drv = $urandom;
    send_bits(8'h01, 8, 1'b1);
    waited = 0;
    while (rise_q.size() - r0 < 10 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    check("midrst_reached_bit10", 32'(rise_q.size() - r0), 32'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_drive", {31'h0, bus.line_drive_low}, 32'h0);
    check("midrst_busy", {31'h0, bus.busy}, 32'h0);
    rst = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    check("midrst_no_done", 32'(done_cnt - d0), 32'h0);
    check("midrst_no_more_pulses", 32'(rise_q.size() - r0), 32'd10);
    check("midrst_code", {24'h0, bus.cmd_code}, 32'h0);
    check("midrst_low_count", 32'(low_q.size() - l0), 32'd10);
    hold(1'b0, 10);

    buttons_drv = $urandom;
    run_cmd("poll_after_rst", 8'h01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n64_controller_responder.md
Name: n64_controller_responder

Overview:
Device-side end of the N64 single-wire joybus. It decodes host command bytes arriving on the shared line and answers with controller status or the live 32-bit button/stick word. It lets the console-side poller be verified in loopback and lets the board act as a controller for an external N64. The open-drain line is never driven high; the top level builds the tri-state from `line_drive_low`.

Parameters:
- US_CYCLES, 50: clk cycles per 1 us; all bus timing derives from it.
- TURNAROUND_US, 2: gap between end of host stop bit and first response bit.
- TIMEOUT_US, 8: maximum low or high phase inside a command before abort.
- STATUS_WORD, 24'h050000: response to 0x00/0xFF (device id 0x0500, no pak).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- line_in, input, 1: raw bus level; asynchronous to clk.
- line_drive_low, output, 1: 1 means pull the bus low; 0 means release (hi-Z).
- buttons, input, 32: current controller word, bit 31 sent first.
- cmd_valid, output, 1: one-cycle pulse when a supported command byte is accepted.
- cmd_code, output, 8: last received command byte; held until the next command.
- cmd_error, output, 1: one-cycle pulse on timeout or unsupported command.
- rsp_done, output, 1: one-cycle pulse after the response stop bit is released.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values:
  - line_drive_low=0, cmd_valid=0, cmd_error=0, rsp_done=0, busy=0, cmd_code=8'h00.
  - Synchronizer flops=1; state=IDLE.
  - Reset mid-response releases the line on the next edge.
- Input path: 2-flop synchronizer, then a falling/rising edge detect on the synced level. All latencies below are counted from the synced level.
- Bit decode: measure the low width from falling edge to rising edge.
  - width < 2*US_CYCLES: bit=1; otherwise bit=0.
  - Bits shift in MSB first.
- FSM states:
  - IDLE: on falling edge → RX_LOW with bit index 0.
  - RX_LOW: counts low time.
    - Rising edge: store the bit → RX_HIGH.
    - Low for TIMEOUT_US: pulse cmd_error → WAIT_RELEASE.
  - RX_HIGH: counts high time.
    - Falling edge with index<8 → RX_LOW.
    - Falling edge with index==8 → RX_STOP.
    - High for TIMEOUT_US: cmd_error → IDLE (partial byte discarded).
  - RX_STOP: the low pulse is the stop bit and its width is not decoded. Timeout is handled as in RX_LOW. Rising edge actions:
    - cmd_code is updated.
    - 0x00, 0x01, 0xFF: pulse cmd_valid. Load the shift register with {STATUS_WORD, 8'h00} and length 24, or with buttons (sampled this cycle) and length 32 → TURNAROUND.
    - Other code: pulse cmd_error → IDLE.
  - TURNAROUND: wait TURNAROUND_US*US_CYCLES cycles; line_in is ignored → TX_LOW.
  - TX_LOW: drive low for 1*US (bit 1) or 3*US (bit 0) → TX_HIGH.
  - TX_HIGH: release for 3*US (bit 1) or 1*US (bit 0).
    - Go to TX_LOW while bits remain.
    - After the last bit → TX_STOP.
  - TX_STOP: drive low for 2*US, then release, pulse rsp_done → IDLE.
  - WAIT_RELEASE: stay until the synced line is high → IDLE.
- Line-in handling during transmit: line_in is ignored in TURNAROUND, TX_* and TX_STOP (own echo).
- Counters: one 16-bit phase counter, cleared on every state change; it saturates and does not wrap.
- Response length: 24 bits for 0x00/0xFF and 32 bits for 0x01; total time = (len*4 + 2) us.
- Latency: line_drive_low rises exactly TURNAROUND_US*US_CYCLES+1 cycles after the cycle the synced line rises at the end of the stop bit.
- Buttons capture: changes to buttons after capture do not affect the response in flight.

Decomposition:
- Package `n64_pkg`:
  - Command constants CMD_STATUS=8'h00, CMD_POLL=8'h01, CMD_RESET=8'hFF.
  - State enum `n64_rsp_state_t`.
  - Bit-phase multipliers (1, 2, 3 us).
  - Shared with the host-side controller.
- Sub-module `n64_bit_encoder`:
  - Given a start pulse, a bit value and US_CYCLES, it drives the low/high phases and pulses done.
  - Reused for the stop bit through a "stop" input that forces 2 us low.

Test Plan:
1. Bench uses US_CYCLES=4. Host drives 0x01 plus stop; buttons=32'hA5C3_0F81.
   - Required: cmd_valid pulses once, cmd_code=8'h01.
   - Required: line_drive_low first rises 9 cycles after stop rising.
   - Required: the decoded 32 bits equal A5C30F81, then a 2 us stop bit and one rsp_done pulse.
2. Host sends 0x00 → 24-bit response 0x050000 plus stop. Repeat with 0xFF → identical response and cmd_code=8'hFF.
3. Host sends 0x02 → cmd_error pulses once and line_drive_low stays 0. The next 0x01 is answered normally.
4. Host drives 5 bits, then holds the line high for 40 cycles → cmd_error at cycle 32 of high, busy=0. A following full 0x01 gets a correct response.
5. Line held low for 50 cycles → cmd_error, FSM stays in WAIT_RELEASE until high. No response is produced.
6. rst asserted during the 10th response bit → line_drive_low=0 next cycle, busy=0, no rsp_done. buttons toggled mid-response in a separate run does not alter the transmitted word.
